ahb_lite_master: RTL and testbench

//  AHB-Lite initiator that turns local word commands into single or incrementing-burst

---
 rtl/ahb_pkg.sv | 44 ++++
 rtl/ahb_beat_ctr.sv | 39 +++
 rtl/ahb_lite_master.sv | 171 +++++++++++++++++
 tb/tb_ahb_lite_master.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the initiator state type.
// Also holds the helpers that normalise beat counts and pick HBURST.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;

   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic [3:0] HPROT_DATA    = 4'b0011;

   localparam logic [1:0] HRESP_OKAY    = 2'b00;
   localparam logic [1:0] HRESP_ERROR   = 2'b01;

   typedef enum logic [2:0] {IDLE, ADDR, XFER, LAST, ERR} master_state_t;

   // Zero means one beat; anything above the limit is cut down to the limit.
   function automatic logic [2:0] clamp_beats(input logic [2:0] beats, input int unsigned max_beats);
      logic [2:0] lim;
      lim = 3'(max_beats);
      if (beats == 3'd0) begin
         return 3'd1;
      end else if (beats > lim) begin
         return lim;
      end else begin
         return beats;
      end
   endfunction

   function automatic logic [2:0] burst_code(input logic [2:0] beats);
      if (beats == 3'd1) begin
         return HBURST_SINGLE;
      end else if (beats == 3'd4) begin
         return HBURST_INCR4;
      end else begin
         return HBURST_INCR;
      end
   endfunction

endpackage

// File: rtl/ahb_beat_ctr.sv
// Beat bookkeeping for an incrementing word burst: current word address and beats left.
// 'last' flags that the address currently presented is the final one of the burst.
module ahb_beat_ctr #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 3
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [CNT_W-1:0]  load_beats,
   input  logic              step,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   logic [ADDR_W-1:0] addr_reg;
   logic [CNT_W-1:0]  cnt_reg;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         addr_reg <= '0;
         cnt_reg  <= '0;
      end else if (load) begin
         // Word aligned: the byte-lane bits of the start address are dropped.
         addr_reg <= load_addr & ~ADDR_W'(3);
         cnt_reg  <= load_beats;
      end else if (step) begin
         addr_reg <= addr_reg + ADDR_W'(4);
         if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
         end
      end
   end

   assign addr = addr_reg;
   assign last = (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: turns one local command into a single or incrementing word burst,
// overlapping each address phase with the previous data phase.
module ahb_lite_master
   import ahb_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_BEATS = 4
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [2:0]        cmd_beats,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_data_req,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] HADDR,
   output logic [1:0]        HTRANS,
   output logic              HWRITE,
   output logic [2:0]        HSIZE,
   output logic [2:0]        HBURST,
   output logic [3:0]        HPROT,
   output logic [DATA_W-1:0] HWDATA,
   input  logic [DATA_W-1:0] HRDATA,
   input  logic              HREADY,
   input  logic [1:0]        HRESP
);

   master_state_t     state_reg, state_next;
   logic              hwrite_reg;
   logic [2:0]        hburst_reg;
   logic [DATA_W-1:0] hwdata_reg;
   logic [DATA_W-1:0] rd_data_reg;
   logic              rd_valid_reg;
   logic              done_reg, done_next;
   logic              error_reg, error_next;
   logic              dp_pending_reg;
   logic              err_seen_reg;

   logic              accept;
   logic              addr_phase;
   logic              addr_accept;
   logic              data_done;
   logic              hresp_err;
   logic              ctr_last;
   logic [2:0]        beats_eff;

   assign accept      = cmd_valid && (state_reg == IDLE);
   assign addr_phase  = (state_reg == ADDR) || (state_reg == XFER);
   assign addr_accept = addr_phase && HREADY;
   assign data_done   = dp_pending_reg && HREADY;
   assign hresp_err   = (HRESP == HRESP_ERROR);
   assign beats_eff   = clamp_beats(cmd_beats, MAX_BEATS);

   ahb_beat_ctr #(
      .ADDR_W (ADDR_W),
      .CNT_W  (3)
   ) u_beat_ctr (
      .HCLK       (HCLK),
      .HRESETn    (HRESETn),
      .load       (accept),
      .load_addr  (cmd_addr),
      .load_beats (beats_eff),
      .step       (addr_accept),
      .addr       (HADDR),
      .last       (ctr_last)
   );

   always_comb begin
      state_next = state_reg;
      done_next  = 1'b0;
      error_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) state_next = ADDR;
         end
         ADDR: begin
            if (HREADY) state_next = ctr_last ? LAST : XFER;
         end
         XFER: begin
            // First cycle of a two-cycle ERROR: drop the pending address next cycle.
            if (hresp_err && !HREADY) begin
               state_next = ERR;
            end else if (HREADY && ctr_last) begin
               state_next = LAST;
            end
         end
         LAST: begin
            if (hresp_err && !HREADY) begin
               state_next = ERR;
            end else if (HREADY) begin
               state_next = IDLE;
               done_next  = 1'b1;
               error_next = err_seen_reg || hresp_err;
            end
         end
         ERR: begin
            if (HREADY) begin
               state_next = IDLE;
               done_next  = 1'b1;
               error_next = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_reg      <= IDLE;
         hwrite_reg     <= 1'b0;
         hburst_reg     <= HBURST_SINGLE;
         hwdata_reg     <= '0;
         rd_data_reg    <= '0;
         rd_valid_reg   <= 1'b0;
         done_reg       <= 1'b0;
         error_reg      <= 1'b0;
         dp_pending_reg <= 1'b0;
         err_seen_reg   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         done_reg     <= done_next;
         error_reg    <= error_next;
         rd_valid_reg <= data_done && !hwrite_reg && !hresp_err;
         if (accept) begin
            hwrite_reg   <= cmd_write;
            hburst_reg   <= burst_code(beats_eff);
            err_seen_reg <= 1'b0;
         end else if (data_done && hresp_err) begin
            err_seen_reg <= 1'b1;
         end
         if (HREADY) begin
            dp_pending_reg <= addr_accept;
         end
         if (addr_accept && hwrite_reg) begin
            hwdata_reg <= wr_data;
         end
         if (data_done && !hwrite_reg && !hresp_err) begin
            rd_data_reg <= HRDATA;
         end
      end
   end

   always_comb begin
      HTRANS = HTRANS_IDLE;
      case (state_reg)
         ADDR:    HTRANS = HTRANS_NONSEQ;
         XFER:    HTRANS = HTRANS_SEQ;
         default: HTRANS = HTRANS_IDLE;
      endcase
   end

   assign cmd_ready   = (state_reg == IDLE);
   assign wr_data_req = addr_accept && hwrite_reg;
   assign HWRITE      = hwrite_reg;
   assign HSIZE       = HSIZE_WORD;
   assign HBURST      = hburst_reg;
   assign HPROT       = HPROT_DATA;
   assign HWDATA      = hwdata_reg;
   assign rd_data     = rd_data_reg;
   assign rd_valid    = rd_valid_reg;
   assign done        = done_reg;
   assign error       = error_reg;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: the bench plays the AHB slave and the write FIFO
// cycle by cycle and checks every output against hand-computed values.
module tb_ahb_lite_master;
   import ahb_pkg::*;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr;
   logic [2:0]  cmd_beats;
   logic [31:0] wr_data;
   logic        wr_data_req;
   logic [31:0] rd_data;
   logic        rd_valid, done, error;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE, HBURST;
   logic [3:0]  HPROT;
   logic [31:0] HWDATA, HRDATA;
   logic        HREADY;
   logic [1:0]  HRESP;

   int          checks = 0;
   int          errors = 0;
   int          pops = 0;
   int          base;
   logic [31:0] fifo [8];

   always #5 HCLK = ~HCLK;

   ahb_lite_master #(
      .ADDR_W    (32),
      .DATA_W    (32),
      .MAX_BEATS (4)
   ) dut (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_beats   (cmd_beats),
      .wr_data     (wr_data),
      .wr_data_req (wr_data_req),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .done        (done),
      .error       (error),
      .HADDR       (HADDR),
      .HTRANS      (HTRANS),
      .HWRITE      (HWRITE),
      .HSIZE       (HSIZE),
      .HBURST      (HBURST),
      .HPROT       (HPROT),
      .HWDATA      (HWDATA),
      .HRDATA      (HRDATA),
      .HREADY      (HREADY),
      .HRESP       (HRESP)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle, then drive the slave response and FIFO head for that cycle.
   task automatic tick_in(input logic rdy, input logic [1:0] resp, input logic [31:0] rdata);
      @(posedge HCLK);
      #1;
      cmd_valid = 1'b0;
      HREADY    = rdy;
      HRESP     = resp;
      HRDATA    = rdata;
      wr_data   = fifo[pops % 8];
      #1;
      if (wr_data_req === 1'b1) pops++;
   endtask

   task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] beats);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_beats = beats;
      #1;
      chk("accept_ready", cmd_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_beats = '0;
      wr_data = '0; HRDATA = '0; HREADY = 1'b1; HRESP = HRESP_OKAY;
      for (int i = 0; i < 8; i++) fifo[i] = '0;

      // Reset state
      repeat (3) @(posedge HCLK);
      #1;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_htrans", HTRANS, HTRANS_IDLE);
      chk("rst_haddr", HADDR, 0);
      chk("rst_hwdata", HWDATA, 0);
      chk("rst_hwrite", HWRITE, 0);
      chk("rst_hburst", HBURST, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_wr_req", wr_data_req, 0);
      HRESETn = 1'b1;
      tick_in(1'b1, HRESP_OKAY, 32'h0);

      // 1: single write
      base = pops;
      fifo[pops % 8] = 32'hDEADBEEF;
      wr_data = fifo[pops % 8];
      issue(1'b1, 32'h10, 3'd1);
      tick_in(1'b1, HRESP_OKAY, 32'h0);
      chk("t1_htrans", HTRANS, HTRANS_NONSEQ);
      chk("t1_hburst", HBURST, HBURST_SINGLE);
      chk("t1_haddr", HADDR, 32'h10);
      chk("t1_hwrite", HWRITE, 1);
      chk("t1_hsize", HSIZE, 3'b010);
      chk("t1_hprot", HPROT, 4'b0011);
      chk("t1_wr_req", wr_data_req, 1);
      chk("t1_ready_busy", cmd_ready, 0);
      tick_in(1'b1, HRESP_OKAY, 32'h0);
      chk("t1_htrans_idle", HTRANS, HTRANS_IDLE);
      chk("t1_hwdata", HWDATA, 32'hDEADBEEF);
      chk("t1_done_early", done, 0);
      chk("t1_wr_req_off", wr_data_req, 0);
      tick_in(1'b1, HRESP_OKAY, 32'h0);
      chk("t1_done", done, 1);
      chk("t1_error", error, 0);
      chk("t1_ready", cmd_ready, 1);
      chk("t1_pops", pops - base, 1);

      // 2: INCR4 read, slave returns 1..4
      issue(1'b0, 32'h100, 3'd4);
      for (int i = 0; i < 4; i++) begin
         tick_in(1'b1, HRESP_OKAY, 32'(i));
         chk("t2_htrans", HTRANS, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ);
         chk("t2_haddr", HADDR, 32'h100 + 32'(4 * i));
         chk("t2_rd_valid", rd_valid, (i >= 2) ? 1 : 0);
         if (i >= 2) chk("t2_rd_data", rd_data, 32'(i - 1));
         if (i == 0) chk("t2_hburst", HBURST, HBURST_INCR4);
      end
      tick_in(1'b1, HRESP_OKAY, 32'd4);
      chk("t2_htrans_last", HTRANS, HTRANS_IDLE);
      chk("t2_rd3", rd_data, 3);
      tick_in(1'b1, HRESP_OKAY, 32'h0);
      chk("t2_rd4_valid", rd_valid, 1);
      chk("t2_rd4", rd_data, 4);
      chk("t2_done", done, 1);
      chk("t2_error", error, 0);
      tick_in(1'b1, HRESP_OKAY, 32'h0);
      chk("t2_done_pulse", done, 0);
      chk("t2_rd_valid_pulse", rd_valid, 0);

      // 3: INCR4 write, two wait states on the second data phase
      base = pops;
      for (int k = 0; k < 4; k++) fifo[(base + k) % 8] = 32'hA5A50000 | 32'(k);
      wr_data = fifo[base % 8];
      issue(1'b1, 32'h200, 3'd4);
      tick_in(1'b1, HRESP_OKAY, 32'h0);
      chk("t3_c1_htrans", HTRANS, HTRANS_NONSEQ);
      chk("t3_c1_req", wr_data_req, 1);
      tick_in(1'b1, HRESP_OKAY, 32'h0);
      chk("t3_c2_haddr", HADDR, 32'h204);
      chk("t3_c2_hwdata", HWDATA, 32'hA5A50000);
      chk("t3_c2_req", wr_data_req, 1);
      for (int s = 0; s < 2; s++) begin
         tick_in(1'b0, HRESP_OKAY, 32'h0);
         chk("t3_stall_htrans", HTRANS, HTRANS_SEQ);
         chk("t3_stall_haddr", HADDR, 32'h208);
         chk("t3_stall_hwdata", HWDATA, 32'hA5A50001);
         chk("t3_stall_req", wr_data_req, 0);
      end
      tick_in(1'b1, HRESP_OKAY, 32'h0);
      chk("t3_c5_haddr", HADDR, 32'h208);
      chk("t3_c5_hwdata", HWDATA, 32'hA5A50001);
      chk("t3_c5_req", wr_data_req, 1);
      tick_in(1'b1, HRESP_OKAY, 32'h0);
      chk("t3_c6_haddr", HADDR, 32'h20C);
      chk("t3_c6_hwdata", HWDATA, 32'hA5A50002);
      chk("t3_c6_req", wr_data_req, 1);
      tick_in(1'b1, HRESP_OKAY, 32'h0);
      chk("t3_c7_htrans", HTRANS, HTRANS_IDLE);
      chk("t3_c7_hwdata", HWDATA, 32'hA5A50003);
      chk("t3_c7_req", wr_data_req, 0);
      tick_in(1'b1, HRESP_OKAY, 32'h0);
      chk("t3_done", done, 1);
      chk("t3_error", error, 0);
      chk("t3_pops", pops - base, 4);

      // 4: 4-beat read, ERROR on the second beat
      issue(1'b0, 32'h300, 3'd4);
      tick_in(1'b1, HRESP_OKAY, 32'h0);
      chk("t4_c1_htrans", HTRANS, HTRANS_NONSEQ);
      tick_in(1'b1, HRESP_OKAY, 32'h11);
      chk("t4_c2_htrans", HTRANS, HTRANS_SEQ);
      tick_in(1'b0, HRESP_ERROR, 32'h0);
      chk("t4_c3_rd_valid", rd_valid, 1);
      chk("t4_c3_rd_data", rd_data, 32'h11);
      chk("t4_c3_htrans", HTRANS, HTRANS_SEQ);
      tick_in(1'b1, HRESP_ERROR, 32'h0);
      chk("t4_c4_htrans", HTRANS, HTRANS_IDLE);
      chk("t4_c4_rd_valid", rd_valid, 0);
      chk("t4_c4_done", done, 0);
      tick_in(1'b1, HRESP_OKAY, 32'h0);
      chk("t4_done", done, 1);
      chk("t4_error", error, 1);
      chk("t4_c5_rd_valid", rd_valid, 0);
      chk("t4_c5_htrans", HTRANS, HTRANS_IDLE);
      tick_in(1'b1, HRESP_OKAY, 32'h0);
      chk("t4_c6_htrans", HTRANS, HTRANS_IDLE);
      chk("t4_c6_done", done, 0);
      chk("t4_c6_error", error, 0);

      // 5: reset asserted mid-burst on beat 3
      issue(1'b0, 32'h400, 3'd4);
      tick_in(1'b1, HRESP_OKAY, 32'h0);
      tick_in(1'b1, HRESP_OKAY, 32'h21);
      tick_in(1'b1, HRESP_OKAY, 32'h22);
      chk("t5_pre_htrans", HTRANS, HTRANS_SEQ);
      chk("t5_pre_haddr", HADDR, 32'h408);
      HRESETn = 1'b0;
      #1;
      chk("t5_rst_htrans", HTRANS, HTRANS_IDLE);
      chk("t5_rst_ready", cmd_ready, 1);
      chk("t5_rst_rd_valid", rd_valid, 0);
      tick_in(1'b1, HRESP_OKAY, 32'h0);
      tick_in(1'b1, HRESP_OKAY, 32'h0);
      HRESETn = 1'b1;
      tick_in(1'b1, HRESP_OKAY, 32'h0);
      chk("t5_post_ready", cmd_ready, 1);
      chk("t5_post_htrans", HTRANS, HTRANS_IDLE);
      chk("t5_post_done", done, 0);
      issue(1'b0, 32'h500, 3'd1);
      tick_in(1'b1, HRESP_OKAY, 32'h0);
      chk("t5_s_htrans", HTRANS, HTRANS_NONSEQ);
      chk("t5_s_haddr", HADDR, 32'h500);
      chk("t5_s_hburst", HBURST, HBURST_SINGLE);
      tick_in(1'b1, HRESP_OKAY, 32'hCAFEF00D);
      chk("t5_s_idle", HTRANS, HTRANS_IDLE);
      tick_in(1'b1, HRESP_OKAY, 32'h0);
      chk("t5_s_done", done, 1);
      chk("t5_s_error", error, 0);
      chk("t5_s_rd_valid", rd_valid, 1);
      chk("t5_s_rd_data", rd_data, 32'hCAFEF00D);

      // 6: beat-count boundaries (0 -> 1, 7 -> 4) and unaligned start
      issue(1'b0, 32'h103, 3'd0);
      tick_in(1'b1, HRESP_OKAY, 32'h0);
      chk("t6_z_hburst", HBURST, HBURST_SINGLE);
      chk("t6_z_haddr", HADDR, 32'h100);
      chk("t6_z_htrans", HTRANS, HTRANS_NONSEQ);
      tick_in(1'b1, HRESP_OKAY, 32'h0);
      chk("t6_z_idle", HTRANS, HTRANS_IDLE);
      tick_in(1'b1, HRESP_OKAY, 32'h0);
      chk("t6_z_done", done, 1);
      issue(1'b0, 32'h600, 3'd7);
      tick_in(1'b1, HRESP_OKAY, 32'h0);
      chk("t6_c_hburst", HBURST, HBURST_INCR4);
      chk("t6_c_haddr0", HADDR, 32'h600);
      tick_in(1'b1, HRESP_OKAY, 32'h0);
      tick_in(1'b1, HRESP_OKAY, 32'h0);
      tick_in(1'b1, HRESP_OKAY, 32'h0);
      chk("t6_c_htrans3", HTRANS, HTRANS_SEQ);
      chk("t6_c_haddr3", HADDR, 32'h60C);
      tick_in(1'b1, HRESP_OKAY, 32'h0);
      chk("t6_c_idle", HTRANS, HTRANS_IDLE);
      chk("t6_c_done_early", done, 0);
      tick_in(1'b1, HRESP_OKAY, 32'h0);
      chk("t6_c_done", done, 1);
      chk("t6_c_error", error, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
